// File: rtl/fpga_cfg_loader_pkg.sv
// Shared definitions for the configuration loader, the fabric top-level and the bench.
package fpga_cfg_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_FINISH = 2'd3
    } cfg_state_e;

    localparam logic CHAIN_CLB  = 1'b0;
    localparam logic CHAIN_CONN = 1'b1;

    localparam int DEF_CLB_CHAIN_LEN  = 4096;
    localparam int DEF_CONN_CHAIN_LEN = 16384;
    localparam int DEF_DIV            = 4;

    function automatic int max_len(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fpga_scan_clkgen.sv
// Scan clock divider: DIV clk cycles low, DIV clk cycles high, parked low when disabled.
module fpga_scan_clkgen
    import fpga_cfg_loader_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    output logic scan_clk_o,
    output logic rise_tick_o,
    output logic fall_tick_o
);

    localparam int              DW         = $clog2(DIV + 1);
    localparam logic [DW-1:0]   CNT_RELOAD = DW'(DIV - 1);

    logic [DW-1:0] cnt_q;
    logic          level_q;

    // Down-counter toggles the scan clock level at terminal count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= CNT_RELOAD;
            level_q <= 1'b0;
        end else if (!en_i) begin
            cnt_q   <= CNT_RELOAD;
            level_q <= 1'b0;
        end else if (cnt_q == '0) begin
            cnt_q   <= CNT_RELOAD;
            level_q <= ~level_q;
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Strobes mark the clk edge on which scan_clk changes level.
    assign rise_tick_o = en_i && (cnt_q == '0) && !level_q;
    assign fall_tick_o = en_i && (cnt_q == '0) && level_q;
    assign scan_clk_o  = level_q;

endmodule

// File: rtl/fpga_cfg_loader.sv
// Byte-stream host front-end that shifts configuration into the CLB or connection
// scan chain and returns the bits shifted out as readback bytes.
//
//   state  | meaning
//   IDLE   | waiting for start
//   FETCH  | cfg_ready high, waiting for a host byte
//   SHIFT  | serialising the captured byte MSB first, one bit per scan_clk period
//   FINISH | scan enable dropped; done/busy update on the way back to IDLE
module fpga_cfg_loader
    import fpga_cfg_loader_pkg::*;
#(
    parameter int CLB_CHAIN_LEN  = DEF_CLB_CHAIN_LEN,
    parameter int CONN_CHAIN_LEN = DEF_CONN_CHAIN_LEN,
    parameter int DIV            = DEF_DIV
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       chain_sel,
    input  logic       cfg_valid,
    input  logic [7:0] cfg_data,
    output logic       cfg_ready,
    output logic       busy,
    output logic       done,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       scan_clk,
    output logic       clb_scan_en,
    output logic       clb_scan_in,
    input  logic       clb_scan_out,
    output logic       conn_scan_en,
    output logic       conn_scan_in,
    input  logic       conn_scan_out
);

    localparam int CW = $clog2(max_len(CLB_CHAIN_LEN, CONN_CHAIN_LEN) + 1);

    cfg_state_e  state_q;
    logic        sel_q;
    logic [CW-1:0] rem_q;
    logic [3:0]  byte_left_q;
    logic [2:0]  shamt_q;
    logic [7:0]  sreg_q;
    logic [7:0]  rb_q;
    logic        busy_q, done_q, cfg_ready_q, rd_valid_q;
    logic [7:0]  rd_data_q;
    logic        clb_en_q, clb_in_q, conn_en_q, conn_in_q;

    logic        rise_tick, fall_tick, scan_clk_w;
    logic        scan_out_d;
    logic [7:0]  rb_d;
    logic [3:0]  byte_n_d;

    fpga_scan_clkgen #(.DIV(DIV)) u_clkgen (
        .clk         (clk),
        .reset       (reset),
        .en_i        (state_q == ST_SHIFT),
        .scan_clk_o  (scan_clk_w),
        .rise_tick_o (rise_tick),
        .fall_tick_o (fall_tick)
    );

    assign scan_out_d = (sel_q == CHAIN_CONN) ? conn_scan_out : clb_scan_out;
    assign rb_d       = {rb_q[6:0], scan_out_d};
    // Bits taken from the next byte: a full byte, or whatever is left of the chain.
    assign byte_n_d   = (rem_q >= CW'(8)) ? 4'd8 : 4'(rem_q);

    // Main sequencer; readback sampling runs alongside on every scan_clk rise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            sel_q       <= CHAIN_CLB;
            rem_q       <= '0;
            byte_left_q <= '0;
            shamt_q     <= '0;
            sreg_q      <= '0;
            rb_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_ready_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            clb_en_q    <= 1'b0;
            clb_in_q    <= 1'b0;
            conn_en_q   <= 1'b0;
            conn_in_q   <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;

            if (rise_tick) begin
                rem_q       <= rem_q - 1'b1;
                byte_left_q <= byte_left_q - 1'b1;
                rb_q        <= rb_d;
                if (byte_left_q == 4'd1) begin
                    // Short final byte is left-justified, zero-padded.
                    rd_valid_q <= 1'b1;
                    rd_data_q  <= rb_d << shamt_q;
                    rb_q       <= '0;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        sel_q       <= chain_sel;
                        rem_q       <= (chain_sel == CHAIN_CONN) ? CW'(CONN_CHAIN_LEN)
                                                                 : CW'(CLB_CHAIN_LEN);
                        busy_q      <= 1'b1;
                        cfg_ready_q <= 1'b1;
                        clb_en_q    <= (chain_sel == CHAIN_CLB);
                        conn_en_q   <= (chain_sel == CHAIN_CONN);
                        state_q     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (cfg_valid && cfg_ready_q) begin
                        sreg_q      <= cfg_data;
                        byte_left_q <= byte_n_d;
                        shamt_q     <= 3'(4'd8 - byte_n_d);
                        cfg_ready_q <= 1'b0;
                        clb_in_q    <= (sel_q == CHAIN_CLB)  & cfg_data[7];
                        conn_in_q   <= (sel_q == CHAIN_CONN) & cfg_data[7];
                        state_q     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (fall_tick) begin
                        if (byte_left_q == 4'd0) begin
                            if (rem_q == '0) begin
                                clb_en_q  <= 1'b0;
                                conn_en_q <= 1'b0;
                                clb_in_q  <= 1'b0;
                                conn_in_q <= 1'b0;
                                state_q   <= ST_FINISH;
                            end else begin
                                cfg_ready_q <= 1'b1;
                                state_q     <= ST_FETCH;
                            end
                        end else begin
                            sreg_q    <= {sreg_q[6:0], 1'b0};
                            clb_in_q  <= (sel_q == CHAIN_CLB)  & sreg_q[6];
                            conn_in_q <= (sel_q == CHAIN_CONN) & sreg_q[6];
                        end
                    end
                end
                ST_FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cfg_ready    = cfg_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;
    assign scan_clk     = scan_clk_w;
    assign clb_scan_en  = clb_en_q;
    assign clb_scan_in  = clb_in_q;
    assign conn_scan_en = conn_en_q;
    assign conn_scan_in = conn_in_q;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Bench for fpga_cfg_loader: scoreboarded scan bits and readback bytes, with
// small behavioural chain models providing the scan_out loopback.
module tb_fpga_cfg_loader;
    import fpga_cfg_loader_pkg::*;

    localparam int CLB_LEN  = 16;
    localparam int CONN_LEN = 12;
    localparam int DIV0     = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start = 1'b0, chain_sel = 1'b0, cfg_valid = 1'b0;
    logic [7:0] cfg_data = 8'h00;
    logic       cfg_ready, busy, done, rd_valid, scan_clk;
    logic [7:0] rd_data;
    logic       clb_scan_en, clb_scan_in, clb_scan_out;
    logic       conn_scan_en, conn_scan_in, conn_scan_out;

    logic       start1 = 1'b0, cfg_valid1 = 1'b0;
    logic [7:0] cfg_data1 = 8'h00;
    logic       cfg_ready1, busy1, done1, rd_valid1, scan_clk1;
    logic [7:0] rd_data1;
    logic       clb_scan_en1, clb_scan_in1, conn_scan_en1, conn_scan_in1;

    logic [CLB_LEN-1:0]  clb_chain = '0;
    logic [CONN_LEN-1:0] conn_chain = '0;
    assign clb_scan_out  = clb_chain[CLB_LEN-1];
    assign conn_scan_out = conn_chain[CONN_LEN-1];

    fpga_cfg_loader #(.CLB_CHAIN_LEN(CLB_LEN), .CONN_CHAIN_LEN(CONN_LEN), .DIV(DIV0)) dut (
        .clk(clk), .reset(rst_n), .start(start), .chain_sel(chain_sel),
        .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
        .busy(busy), .done(done), .rd_valid(rd_valid), .rd_data(rd_data),
        .scan_clk(scan_clk),
        .clb_scan_en(clb_scan_en), .clb_scan_in(clb_scan_in), .clb_scan_out(clb_scan_out),
        .conn_scan_en(conn_scan_en), .conn_scan_in(conn_scan_in), .conn_scan_out(conn_scan_out)
    );

    fpga_cfg_loader #(.CLB_CHAIN_LEN(8), .CONN_CHAIN_LEN(CONN_LEN), .DIV(1)) dut1 (
        .clk(clk), .reset(rst_n), .start(start1), .chain_sel(CHAIN_CLB),
        .cfg_valid(cfg_valid1), .cfg_data(cfg_data1), .cfg_ready(cfg_ready1),
        .busy(busy1), .done(done1), .rd_valid(rd_valid1), .rd_data(rd_data1),
        .scan_clk(scan_clk1),
        .clb_scan_en(clb_scan_en1), .clb_scan_in(clb_scan_in1), .clb_scan_out(1'b0),
        .conn_scan_en(conn_scan_en1), .conn_scan_in(conn_scan_in1), .conn_scan_out(1'b0)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard queues and monitor state
    logic       exp_bits[$];
    logic [7:0] exp_rd[$];
    int   rises = 0, done_cnt = 0, hi_cnt = 0, viol_cnt = 0;
    logic prev_sc = 1'b0;
    logic cur_sel = 1'b0;
    bit   load_active = 1'b0;
    logic [31:0] e_bit, e_rd;

    // Watches scan_clk edges, checks presented bits and readback, models the chains.
    always @(negedge clk) begin
        if (!rst_n) begin
            clb_chain  <= '0;
            conn_chain <= '0;
            hi_cnt = 0;
        end else begin
            if (scan_clk && !prev_sc) begin
                rises++;
                hi_cnt = 1;
                e_bit = (exp_bits.size() > 0) ? 32'(exp_bits.pop_front()) : 'x;
                chk("scan_in", 32'(cur_sel ? conn_scan_in : clb_scan_in), e_bit);
                chk("scan_en", 32'(cur_sel ? conn_scan_en : clb_scan_en), 32'd1);
                if (clb_scan_en)  clb_chain  <= {clb_chain[CLB_LEN-2:0], clb_scan_in};
                if (conn_scan_en) conn_chain <= {conn_chain[CONN_LEN-2:0], conn_scan_in};
            end else if (scan_clk) begin
                hi_cnt++;
            end else if (prev_sc) begin
                chk("hi_len", hi_cnt, DIV0);
            end
            if (rd_valid) begin
                e_rd = (exp_rd.size() > 0) ? 32'(exp_rd.pop_front()) : 'x;
                chk("rd_data", 32'(rd_data), e_rd);
            end
            if (done) done_cnt++;
            if (load_active && (cur_sel ? (clb_scan_en | clb_scan_in)
                                        : (conn_scan_en | conn_scan_in)))
                viol_cnt++;
        end
        prev_sc = scan_clk;
    end

    // DIV=1 instance monitor: rise spacing, shifted bits, readback count.
    int   rises1 = 0, since1 = 0, rd1_cnt = 0;
    bit   have_prev1 = 1'b0;
    logic prev_sc1 = 1'b0;
    logic [7:0] bits1 = 8'hFF;
    logic [7:0] rd1_last = 8'hFF;
    always @(negedge clk) begin
        if (rst_n) begin
            if (scan_clk1 && !prev_sc1) begin
                rises1++;
                bits1 = {bits1[6:0], clb_scan_in1};
                if (have_prev1) chk("div1_period", since1, 2);
                have_prev1 = 1'b1;
                since1 = 1;
            end else begin
                since1++;
            end
            if (rd_valid1) begin
                rd1_cnt++;
                rd1_last = rd_data1;
            end
        end
        prev_sc1 = scan_clk1;
    end

    task automatic send_byte(input logic [7:0] d);
        int t;
        t = 0;
        cfg_valid = 1'b1;
        cfg_data  = d;
        while (!cfg_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("hs_timeout", 32'(t < 2000), 32'd1);
        @(posedge clk);
        #1 cfg_valid = 1'b0;
    endtask

    logic [15:0] prev_clb = '0, prev_conn = '0;

    task automatic do_load(input logic sel, input logic [15:0] data, input bit stall, input bit mid_start);
        int len, r0, d0, v0, rs, t;
        logic [15:0] old;
        logic sc_seen, en_low;
        len = (sel == CHAIN_CONN) ? CONN_LEN : CLB_LEN;
        old = (sel == CHAIN_CONN) ? prev_conn : prev_clb;
        exp_rd.push_back(old[15:8]);
        exp_rd.push_back(old[7:0]);
        if (sel == CHAIN_CONN) prev_conn = data & 16'hFFF0;
        else                   prev_clb  = data;
        for (int i = 0; i < len; i++) exp_bits.push_back(data[15-i]);
        r0 = rises; d0 = done_cnt; v0 = viol_cnt;
        cur_sel = sel;
        load_active = 1'b1;
        @(posedge clk); #1 start = 1'b1; chain_sel = sel;
        @(posedge clk); #1 start = 1'b0; chain_sel = 1'b0;
        @(negedge clk);
        chk("busy_rise", 32'(busy), 32'd1);
        for (int b = 0; b < 2; b++) begin
            if (b == 1 && stall) begin
                t = 0;
                while (!cfg_ready && t < 2000) begin
                    @(negedge clk);
                    t++;
                end
                rs = rises; sc_seen = 1'b0; en_low = 1'b0;
                repeat (50) begin
                    @(negedge clk);
                    sc_seen |= scan_clk;
                    en_low  |= !(sel ? conn_scan_en : clb_scan_en);
                end
                chk("stall_rises", rises - rs, 0);
                chk("stall_sclk", 32'(sc_seen), 32'd0);
                chk("stall_en", 32'(en_low), 32'd0);
            end
            send_byte(data[15-8*b -: 8]);
            if (b == 0 && mid_start) begin
                repeat (6) @(negedge clk);
                start = 1'b1; chain_sel = ~sel;
                @(negedge clk);
                start = 1'b0; chain_sel = 1'b0;
            end
        end
        t = 0;
        while (done_cnt == d0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("done_timeout", 32'(t < 2000), 32'd1);
        repeat (5) @(negedge clk);
        chk("rises", rises - r0, len);
        chk("done_count", done_cnt - d0, 1);
        chk("busy_fall", 32'(busy), 32'd0);
        chk("unsel_quiet", viol_cnt - v0, 0);
        chk("bits_left", exp_bits.size(), 0);
        chk("rd_left", exp_rd.size(), 0);
        load_active = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int t;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd0);
        chk("rst_sclk", 32'(scan_clk), 32'd0);
        chk("rst_en", 32'({clb_scan_en, conn_scan_en, clb_scan_in, conn_scan_in}), 32'd0);
        chk("rst_out", 32'({done, rd_valid, rd_data}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_load(CHAIN_CLB,  16'hA53C, 1'b0, 1'b0);
        do_load(CHAIN_CONN, 16'hFF9F, 1'b0, 1'b0);
        do_load(CHAIN_CONN, 16'hFF9F, 1'b1, 1'b0);
        do_load(CHAIN_CLB,  16'h1234, 1'b0, 1'b1);

        // Reset in the middle of a high scan_clk phase.
        for (int i = 0; i < 8; i++) exp_bits.push_back(t_bit(8'h5A, i));
        cur_sel = CHAIN_CLB;
        @(posedge clk); #1 start = 1'b1; chain_sel = CHAIN_CLB;
        @(posedge clk); #1 start = 1'b0;
        send_byte(8'h5A);
        t = 0;
        while (!scan_clk && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("sclk_high_timeout", 32'(t < 200), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sclk", 32'(scan_clk), 32'd0);
        chk("arst_en", 32'(clb_scan_en), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(cfg_ready), 32'd0);
        exp_bits.delete();
        exp_rd.delete();
        prev_clb = '0;
        prev_conn = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        do_load(CHAIN_CLB, 16'hC381, 1'b0, 1'b0);

        // DIV=1 instance: one byte into an 8-bit chain.
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        cfg_valid1 = 1'b1;
        cfg_data1  = 8'h01;
        t = 0;
        while (!cfg_ready1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1 cfg_valid1 = 1'b0;
        t = 0;
        while (!done1 && t < 200) begin
            @(posedge clk);
            #1 t++;
        end
        chk("div1_latency", t, 2 * 1 * 8 + 1);
        repeat (4) @(negedge clk);
        chk("div1_rises", rises1, 8);
        chk("div1_bits", 32'(bits1), 32'h01);
        chk("div1_rd_cnt", rd1_cnt, 1);
        chk("div1_rd", 32'(rd1_last), 32'h00);
        chk("div1_busy", 32'(busy1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic t_bit(input logic [7:0] d, input int i);
        return d[7-i];
    endfunction

endmodule

// File: doc/fpga_cfg_loader.md
Name: fpga_cfg_loader

Overview:
- Configuration front-end that sits directly upstream of the fabric core and drives its CLB and connection scan chains from a byte-stream host interface.
- Serialises host bytes MSB-first onto the selected chain and generates the chain's scan clock and scan-enable.
- Returns the bits shifted out of the chain as readback bytes.
- Runs entirely in the system clock domain; the scan clock is a registered, divided output.

Parameters:
- CLB_CHAIN_LEN, 4096, number of bits in the CLB scan chain.
- CONN_CHAIN_LEN, 16384, number of bits in the connection scan chain.
- DIV, 4, scan-clock half-period in clk cycles (>=1).

Ports:
- clk  input  1  system clock; all state is updated on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a chain load; sampled only in IDLE.
- chain_sel  input  1  chain select, sampled with start: 0 = CLB chain, 1 = connection chain.
- cfg_valid  input  1  host byte valid.
- cfg_data  input  8  host byte, shifted MSB first.
- cfg_ready  output  1  loader accepts cfg_data when cfg_valid && cfg_ready.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse when the load completes.
- rd_valid  output  1  one-cycle pulse; rd_data holds a readback byte.
- rd_data  output  8  readback byte, first-out bit in the MSB.
- scan_clk  output  1  scan clock to the core.
- clb_scan_en  output  1  CLB chain scan enable.
- clb_scan_in  output  1  CLB chain serial data.
- clb_scan_out  input  1  CLB chain serial return.
- conn_scan_en  output  1  connection chain scan enable.
- conn_scan_in  output  1  connection chain serial data.
- conn_scan_out  input  1  connection chain serial return.

Behaviour:
- Reset (reset low, asynchronous): state IDLE; all outputs 0; bit counter and readback register cleared.
- FSM states: IDLE -> FETCH -> SHIFT -> (FETCH | FINISH) -> IDLE.
- IDLE:
  - start=1 latches chain_sel and loads LEN = the selected chain length.
  - busy rises the next cycle; the selected *_scan_en rises the same cycle; go to FETCH.
  - The unselected chain's en/in stay 0 for the whole load.
- FETCH:
  - cfg_ready=1; wait for cfg_valid.
  - On handshake, capture the byte into an 8-bit shift register, drop cfg_ready the next cycle, go to SHIFT.
  - No timeout: the loader waits indefinitely.
- SHIFT, per bit (2*DIV clk cycles):
  - Low phase: scan_clk=0, *_scan_in = current MSB, held for DIV cycles.
  - Rising edge: at the cycle scan_clk goes 1, sample *_scan_out into the readback register; the core shifts on this edge.
  - High phase: lasts DIV cycles, then scan_clk returns to 0 and the next bit is presented.
  - Bits shifted per byte = min(8, bits remaining).
- After each byte or partial byte:
  - If bits remain, go to FETCH.
  - Otherwise go to FINISH.
- Non-multiple-of-8 lengths: the last byte's unused low bits are discarded and never shifted.
- Readback:
  - rd_valid pulses for one clk on the cycle after every 8th sampled bit.
  - For the final partial byte it pulses once, left-justified and zero-padded.
  - There is no backpressure on readback.
- FINISH:
  - scan_clk=0, *_scan_in=0.
  - *_scan_en drops, then one cycle later done pulses, busy drops, and the FSM returns to IDLE.
- start asserted while busy: ignored.
- cfg_valid outside FETCH: ignored (no handshake because cfg_ready=0).
- Reset mid-load:
  - All outputs return to 0 immediately; the partial chain contents are undefined.
  - The host must restart the load.
- Total scan_clk rising edges per load = LEN exactly.
- Counter width = $clog2(max(CLB_CHAIN_LEN, CONN_CHAIN_LEN)+1).
- Divider counter width = $clog2(DIV+1).

Decomposition:
- Shared package: FSM state encoding, chain_sel encodings (CHAIN_CLB=0, CHAIN_CONN=1) and the default chain lengths, reused by the fabric top-level and the bench.
- One natural sub-module, fpga_scan_clkgen: a DIV counter that produces the scan_clk level plus rise_tick and fall_tick strobes, enabled only in SHIFT.

Test Plan:
- CLB load, CLB_CHAIN_LEN=16, DIV=2: start, chain_sel=0, bytes 0xA5 and 0x3C -> clb_scan_in sequence 1010010100111100; exactly 16 scan_clk rises, each high 2 clk; done pulses once; conn_scan_* stay 0.
- Partial byte, CONN_CHAIN_LEN=12: bytes 0xFF and 0x9F -> 12 rises; final bits 1001.
  - Loopback conn_scan_out = conn_scan_in delayed 12 bits: first two rd_data 0x00 and 0x00 (zero-padded), one load later rd_data = 0xFF then 0x90.
- Host stall: hold cfg_valid=0 for 50 clk mid-load -> scan_clk stays 0, scan_en stays 1, no extra rises; the load resumes correctly.
- start while busy (pulse at the midpoint of a load) -> ignored; edge count and done count unchanged.
- Async reset asserted mid-SHIFT with scan_clk=1 -> scan_clk, *_scan_en, busy and cfg_ready all 0 immediately, without waiting for a clk edge.
  - A following fresh load completes normally.
- DIV=1 corner, CLB length 8, byte 0x01 -> scan_clk period 2 clk; done occurs 16 clk after the handshake plus the fixed FETCH/FINISH overhead.
